// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch controller.
package stopwatch_pkg;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;
endpackage

// File: rtl/key_event.sv
// Per-key event extractor: armed press detect plus saturating hold counter
// producing short (release) and long (hold threshold) events.
module key_event #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter bit          LONG_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o,
  output logic short_o,
  output logic long_o
);
  localparam int unsigned     CW     = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0]   LONG_V = CW'(LONG_CYCLES);

  logic          hist_q;
  logic          armed_q;
  logic [CW-1:0] h_q, h_d;

  // h_q == 0 means "no armed hold in progress", so a key held through reset never counts.
  always_comb begin
    press_o = armed_q & hist_q & ~key_n_i;
    h_d     = h_q;
    if (key_n_i)
      h_d = '0;
    else if (press_o)
      h_d = CW'(1);
    else if (h_q != '0 && h_q != LONG_V)
      h_d = h_q + 1'b1;
    long_o  = LONG_EN && !key_n_i && (h_q == LONG_V - 1'b1);
    short_o = key_n_i && (h_q != '0) && (!LONG_EN || h_q != LONG_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q  <= 1'b1;
      armed_q <= 1'b0;
      h_q     <= '0;
    end else begin
      hist_q  <= key_n_i;
      armed_q <= armed_q | key_n_i;
      h_q     <= h_d;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: start/stop and lap/clear keys drive run/freeze levels
// and one-cycle clear/lap pulses, all registered.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_start_n,
  input  logic               key_lap_n,
  output logic               run,
  output logic               freeze,
  output logic               clear_pulse,
  output logic               lap_pulse,
  output logic [STATE_W-1:0] state
);
  logic s_press, s_short, s_long;
  logic l_press, l_short, l_long;
  logic start_unused;

  sw_state_e state_q;
  logic      run_q, freeze_q, clear_q, lap_q;

  key_event #(.LONG_CYCLES(LONG_CYCLES), .LONG_EN(1'b0)) u_key_start (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_start_n),
    .press_o(s_press), .short_o(s_short), .long_o(s_long)
  );

  key_event #(.LONG_CYCLES(LONG_CYCLES), .LONG_EN(1'b1)) u_key_lap (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_lap_n),
    .press_o(l_press), .short_o(l_short), .long_o(l_long)
  );

  assign start_unused = &{1'b0, s_short, s_long, l_press};

  // Priority: long lap > start press > short lap; losers are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
      lap_q    <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      lap_q   <= 1'b0;
      if (l_long) begin
        state_q  <= IDLE;
        run_q    <= 1'b0;
        freeze_q <= 1'b0;
        clear_q  <= 1'b1;
      end else if (s_press) begin
        case (state_q)
          IDLE, PAUSE: begin
            state_q  <= RUN;
            run_q    <= 1'b1;
            freeze_q <= 1'b0;
          end
          RUN, LAP: begin
            state_q  <= PAUSE;
            run_q    <= 1'b0;
            freeze_q <= 1'b0;
          end
          default: ;
        endcase
      end else if (l_short) begin
        case (state_q)
          RUN: begin
            state_q  <= LAP;
            run_q    <= 1'b1;
            freeze_q <= 1'b1;
            lap_q    <= 1'b1;
          end
          LAP: begin
            state_q  <= RUN;
            run_q    <= 1'b1;
            freeze_q <= 1'b0;
          end
          PAUSE: begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            freeze_q <= 1'b0;
            clear_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign state       = state_q;
  assign run         = run_q;
  assign freeze      = freeze_q;
  assign clear_pulse = clear_q;
  assign lap_pulse   = lap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random key traffic,
// checked every cycle against an event-level reference model.
module tb_stopwatch_ctrl;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_lap_n = 1'b1;
  logic       run, freeze, clear_pulse, lap_pulse;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // reference model
  int m_state = 0;
  int m_clr = 0, m_lap = 0;
  int m_prev_s = 1, m_prev_l = 1;
  int m_arm_s = 0, m_arm_l = 0;
  int m_hold = 0;

  stopwatch_ctrl #(.LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_lap_n(key_lap_n),
    .run(run), .freeze(freeze), .clear_pulse(clear_pulse), .lap_pulse(lap_pulse),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int s, input int l, input int r);
    int sp, lp, lg, sh, old;
    if (r == 0) begin
      m_state = 0; m_clr = 0; m_lap = 0;
      m_prev_s = 1; m_prev_l = 1; m_arm_s = 0; m_arm_l = 0; m_hold = 0;
      return;
    end
    sp  = (m_arm_s && m_prev_s == 1 && s == 0) ? 1 : 0;
    lp  = (m_arm_l && m_prev_l == 1 && l == 0) ? 1 : 0;
    old = m_hold;
    if (l == 1)          m_hold = 0;
    else if (lp == 1)    m_hold = 1;
    else if (m_hold > 0) m_hold = (m_hold + 1 > L) ? L : m_hold + 1;
    lg = (l == 0 && old > 0 && old < L && m_hold == L) ? 1 : 0;
    sh = (l == 1 && old > 0 && old < L) ? 1 : 0;
    m_arm_s = m_arm_s | s; m_arm_l = m_arm_l | l;
    m_prev_s = s; m_prev_l = l;
    m_clr = 0; m_lap = 0;
    if (lg == 1) begin
      m_state = 0; m_clr = 1;
    end else if (sp == 1) begin
      m_state = (m_state == 0 || m_state == 2) ? 1 : 2;
    end else if (sh == 1) begin
      case (m_state)
        1: begin m_state = 3; m_lap = 1; end
        3: m_state = 1;
        2: begin m_state = 0; m_clr = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"},  int'(state),       m_state);
    chk({tag, ".run"},    int'(run),         (m_state == 1 || m_state == 3) ? 1 : 0);
    chk({tag, ".freeze"}, int'(freeze),      (m_state == 3) ? 1 : 0);
    chk({tag, ".clear"},  int'(clear_pulse), m_clr);
    chk({tag, ".lap"},    int'(lap_pulse),   m_lap);
    chk({tag, ".excl"},   int'(clear_pulse & lap_pulse), 0);
  endtask

  task automatic step(input int s, input int l, input int r, input string tag);
    key_start_n = s[0];
    key_lap_n   = l[0];
    rst_n       = r[0];
    @(posedge clk);
    #1;
    model_edge(s, l, r);
    check_model(tag);
  endtask

  initial begin
    #1;
    // reset
    step(1, 1, 0, "rst");
    step(1, 1, 0, "rst");
    chk("rst.state_const", int'(state), 0);
    chk("rst.run_const", int'(run), 0);

    // start, stop
    step(1, 1, 1, "s29");
    step(0, 1, 1, "s29");
    chk("s29.run_on", int'(state), 1);
    step(1, 1, 1, "s29");
    step(1, 1, 1, "s29");
    step(0, 1, 1, "s29");
    chk("s29.pause", int'(state), 2);
    chk("s29.run_off", int'(run), 0);

    // back to RUN, short laps
    step(1, 1, 1, "s30");
    step(0, 1, 1, "s30");
    for (int i = 0; i < 3; i++) step(1, 0, 1, "s30");
    step(1, 1, 1, "s30");
    chk("s30.lap_state", int'(state), 3);
    chk("s30.lap_pulse", int'(lap_pulse), 1);
    chk("s30.freeze", int'(freeze), 1);
    step(1, 1, 1, "s30");
    chk("s30.lap_pulse_end", int'(lap_pulse), 0);
    step(1, 0, 1, "s30");
    step(1, 0, 1, "s30");
    step(1, 1, 1, "s30");
    chk("s30.back_run", int'(state), 1);
    chk("s30.unfreeze", int'(freeze), 0);

    // long hold in RUN
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 1, "s31");
      if (i == 7) chk("s31.pre_long", int'(state), 1);
      if (i == 8) begin
        chk("s31.long_state", int'(state), 0);
        chk("s31.long_clear", int'(clear_pulse), 1);
      end
      if (i == 9) chk("s31.clear_once", int'(clear_pulse), 0);
    end
    step(1, 1, 1, "s31");
    chk("s31.release_quiet", int'(state), 0);

    // PAUSE short lap clears; IDLE short lap does nothing
    step(0, 1, 1, "s32");
    step(1, 1, 1, "s32");
    step(0, 1, 1, "s32");
    step(1, 1, 1, "s32");
    chk("s32.pause", int'(state), 2);
    step(1, 0, 1, "s32");
    step(1, 0, 1, "s32");
    step(1, 1, 1, "s32");
    chk("s32.idle", int'(state), 0);
    chk("s32.clear", int'(clear_pulse), 1);
    step(1, 0, 1, "s32");
    step(1, 1, 1, "s32");
    chk("s32.idle_nop", int'(state), 0);
    chk("s32.idle_nopulse", int'(clear_pulse | lap_pulse), 0);

    // start key held across reset release
    step(0, 1, 0, "s33");
    step(0, 1, 0, "s33");
    for (int i = 0; i < 3; i++) step(0, 1, 1, "s33");
    chk("s33.no_press", int'(state), 0);
    step(1, 1, 1, "s33");
    step(0, 1, 1, "s33");
    chk("s33.repress", int'(state), 1);

    // coincident start press with long event, then with short release
    step(1, 1, 1, "s34");
    for (int i = 0; i < 7; i++) step(1, 0, 1, "s34");
    step(0, 0, 1, "s34");
    chk("s34.long_wins", int'(state), 0);
    chk("s34.long_clear", int'(clear_pulse), 1);
    step(1, 1, 1, "s34");
    step(0, 1, 1, "s34");
    step(1, 0, 1, "s34");
    step(1, 0, 1, "s34");
    step(0, 1, 1, "s34");
    chk("s34.start_wins", int'(state), 2);
    chk("s34.no_lap", int'(lap_pulse), 0);

    // reset mid-hold abandons the hold
    step(1, 1, 1, "r25");
    step(0, 1, 1, "r25");
    for (int i = 0; i < 4; i++) step(1, 0, 1, "r25");
    step(1, 0, 0, "r25");
    for (int i = 0; i < 10; i++) step(1, 0, 1, "r25");
    step(1, 1, 1, "r25");
    chk("r25.no_event", int'(state), 0);
    chk("r25.no_pulse", int'(clear_pulse | lap_pulse), 0);

    // random traffic with sticky keys and rare resets
    begin
      int s = 1, l = 1, r;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 3) == 0) s = 1 - s;
        if ($urandom_range(0, 5) == 0) l = 1 - l;
        r = ($urandom_range(0, 99) == 0) ? 0 : 1;
        step(s, l, r, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50_000_000: lap-key hold length in clk cycles that qualifies as a long press; legal range is at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port key_start_n  input  1  debounced start/stop key, active-low, synchronous to clk.
REQ-005 SHALL have port key_lap_n  input  1  debounced lap/clear key, active-low, synchronous to clk.
REQ-006 SHALL have port run  output  1  level; 1 while the counter should advance (RUN or LAP).
REQ-007 SHALL have port freeze  output  1  level; 1 in LAP, meaning the display holds the lap value.
REQ-008 SHALL have port clear_pulse  output  1  one-cycle pulse; zero the time counter.
REQ-009 SHALL have port lap_pulse  output  1  one-cycle pulse; capture the lap value.
REQ-010 SHALL have port state  output  2  current FSM state.

Function
REQ-011 SHALL register all outputs; each output SHALL reflect the clock edge that first samples the qualifying input.
REQ-012 SHALL detect a press as the key sampled 1 on the previous edge and 0 on the current edge, and only while that key is armed.
REQ-013 SHALL keep a per-key armed flag; the flag is cleared by reset and set on the first edge where the key samples 1, so a key held through reset release never produces a press.
REQ-014 SHALL count lap-key hold length h as consecutive edges sampled low after an armed press; h saturates at LONG_CYCLES and clears when the key samples high.
REQ-015 SHALL fire a long event on the edge where h reaches LONG_CYCLES, exactly once per hold.
REQ-016 SHALL fire a short lap event on the release edge when h < LONG_CYCLES; a release after a long event SHALL do nothing.
REQ-017 SHALL implement states IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-018 SHALL make these start-press transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE, with freeze dropping.
REQ-019 SHALL make these short-lap transitions: RUN->LAP with lap_pulse; LAP->RUN; PAUSE->IDLE with clear_pulse; IDLE has no effect.
REQ-020 SHALL, on a long event in any state, go to IDLE and assert clear_pulse.
REQ-021 SHALL, when events coincide in one cycle, apply only the highest priority: long > start press > short lap; lower-priority events are discarded, not queued.
REQ-022 SHALL drive run = (state==RUN or LAP) and freeze = (state==LAP).
REQ-023 SHALL never assert clear_pulse and lap_pulse in the same cycle.

Reset
REQ-024 SHALL, while rst_n=0 on a clock edge, set state=IDLE, run=0, freeze=0, clear_pulse=0, lap_pulse=0, both key history regs=1, both armed flags=0, h=0.
REQ-025 SHALL abandon any in-progress hold count when reset is asserted mid-hold; no long or short event fires for that hold after reset release.

Structure
REQ-026 SHALL place the state encoding (IDLE/RUN/PAUSE/LAP) and the 2-bit state width in a shared package, stopwatch_pkg.
REQ-027 SHALL use one sub-module, key_event, instantiated per key; it contains the history reg, armed flag, saturating hold counter of width $clog2(LONG_CYCLES+1), and press/short/long outputs, and its long-press logic is enabled by parameter.
REQ-028 SHALL keep the FSM and output registers in stopwatch_ctrl.

Verification (bench LONG_CYCLES=8)
REQ-029 SHALL cover: reset, then start press, 3 cycles later start press again -> state 0->1->2; run 0->1->0; no pulses.
REQ-030 SHALL cover: in RUN, lap held 3 cycles then released -> on the release edge state=3, lap_pulse=1 for 1 cycle, freeze=1, run=1; second short lap -> state=1, freeze=0.
REQ-031 SHALL cover: in RUN, lap held 20 cycles -> on the 8th low edge state=0, clear_pulse=1 for exactly 1 cycle; release produces no further event.
REQ-032 SHALL cover: in PAUSE, short lap (2 cycles) -> state=0, clear_pulse=1 once; in IDLE, short lap -> no change, no pulse.
REQ-033 SHALL cover: key_start_n held 0 across reset release -> no transition; after release and a re-press -> state=1.
REQ-034 SHALL cover: start press on the same edge as the lap long event -> state=0 and clear_pulse=1; start press on the same edge as a short-lap release in RUN -> state=2, lap_pulse=0.
